fetch_sequencer: RTL and testbench

- Controls the dual-issue instruction fetch datapath. Owns the program counter, drives the fetch address and captures the two 32-bit instructions returned from instruction memory in the same cycle.
- Buffers fetched pairs in a small FIFO toward decode with a valid/ready handshake.
- Handles branch redirects, halt on a stop instruction, and wrap-around at the end of instruction memory.

---
 rtl/spu_fetch_pkg.sv | 24 ++
 rtl/fetch_pair_fifo.sv | 51 +++++
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spu_fetch_pkg.sv
// rtl/spu_fetch_pkg.sv - shared types and defaults for the dual-issue fetch sequencer
package spu_fetch_pkg;

  localparam int          PC_LIMIT_DEFAULT = 2000;
  localparam logic [10:0] HALT_OP_DEFAULT  = 11'h000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_t;

  // pc is carried at full 32 bits so the struct does not depend on ADDR_W
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [1:0]  slot_v;
  } fetch_pair_t;

  function automatic logic is_halt(input logic [31:0] instr, input logic [10:0] op);
    return instr[31:21] == op;
  endfunction

endpackage

// File: rtl/fetch_pair_fifo.sv
// rtl/fetch_pair_fifo.sv - small FIFO of fetched instruction pairs toward decode
module fetch_pair_fifo
  import spu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_pair_t din,
  output logic        full,
  output logic        empty,
  output fetch_pair_t head
);

  localparam int PW = $clog2(DEPTH);

  fetch_pair_t   mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  // extra pointer bit distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // pointer update; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // storage write; contents are only observed while the entry is valid
  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC control, pair capture, redirect/halt handling; FETCH_PERF_CNT_EN adds perf counters
module fetch_sequencer
  import spu_fetch_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          DEPTH    = 2,
  parameter int          RESET_PC = 0,
  parameter int          PC_LIMIT = PC_LIMIT_DEFAULT,
  parameter logic [10:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_en,
  input  logic [31:0]       instr1_i,
  input  logic [31:0]       instr2_i,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr1,
  output logic [31:0]       out_instr2,
  output logic [1:0]        out_slot_v,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       pairs_fetched,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(PC_LIMIT);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              full, empty, pop;
  logic [1:0]        slot_v;
  logic              halt_hit;
  logic [ADDR_W:0]   pc_plus8;
  fetch_pair_t       enq_pair, head;
  logic              unused_bits;

  assign fetch_pc = pc_q;
  // held low during reset so nothing downstream sees a phantom fetch
  assign fetch_en = reset && (state_q == RUN) && !full && !br_valid;
  assign pop      = out_valid && out_ready && !br_valid;
  assign halted   = (state_q == HALT);

  assign out_valid  = !empty;
  assign out_pc     = empty ? '0    : head.pc[ADDR_W-1:0];
  assign out_instr1 = empty ? '0    : head.instr1;
  assign out_instr2 = empty ? '0    : head.instr2;
  assign out_slot_v = empty ? 2'b00 : head.slot_v;

  assign unused_bits = ^{br_target[1:0], head.pc};

  // next state, next PC, slot masking and halt detection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    halt_hit   = 1'b0;
    slot_v     = misalign_q ? 2'b10 : 2'b11;
    pc_plus8   = {1'b0, pc_q} + (ADDR_W+1)'(8);
    if (slot_v[0] && is_halt(instr1_i, HALT_OP)) begin
      halt_hit = 1'b1;
      slot_v   = 2'b01;
    end else if (slot_v[1] && is_halt(instr2_i, HALT_OP)) begin
      halt_hit = 1'b1;
    end
    enq_pair = '{pc: 32'(pc_q), instr1: instr1_i, instr2: instr2_i, slot_v: slot_v};
    if (br_valid) begin
      state_d = RUN;
      if ({1'b0, br_target} >= LIMIT) begin
        pc_d       = '0;
        misalign_d = 1'b0;
      end else begin
        pc_d       = {br_target[ADDR_W-1:3], 3'b000};
        misalign_d = br_target[2];
      end
    end else if (fetch_en) begin
      pc_d       = (pc_plus8 >= LIMIT) ? '0 : pc_plus8[ADDR_W-1:0];
      misalign_d = 1'b0;
      if (halt_hit)
        state_d = HALT;
    end
  end

  // sequencer state, PC and misaligned-redirect flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= ADDR_W'(RESET_PC);
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fetch_en),
    .pop   (pop),
    .flush (br_valid),
    .din   (enq_pair),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef FETCH_PERF_CNT_EN
  // saturating counters of fetched pairs and stalled RUN cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pairs_fetched <= '0;
      stall_cycles  <= '0;
    end else begin
      if (fetch_en && pairs_fetched != '1)
        pairs_fetched <= pairs_fetched + 32'd1;
      if (state_q == RUN && !fetch_en && !br_valid && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] fetch_pc;
  logic        fetch_en;
  logic [31:0] instr1_i, instr2_i;
  logic        br_valid;
  logic [11:0] br_target;
  logic        out_valid, out_ready;
  logic [11:0] out_pc;
  logic [31:0] out_instr1, out_instr2;
  logic [1:0]  out_slot_v;
  logic        halted;
  logic [11:0] halt_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pairs_fetched, stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_pc   (fetch_pc),
    .fetch_en   (fetch_en),
    .instr1_i   (instr1_i),
    .instr2_i   (instr2_i),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr1 (out_instr1),
    .out_instr2 (out_instr2),
    .out_slot_v (out_slot_v),
    .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .pairs_fetched (pairs_fetched),
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // instruction memory: tagged words, with a stop word in slot 0 at halt_pc
  always_comb begin
    instr1_i = 32'hA000_0000 | 32'(fetch_pc);
    instr2_i = 32'hB000_0000 | 32'(fetch_pc + 12'd4);
    if (fetch_pc == halt_pc)
      instr1_i = 32'h0000_0123;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b1;
    br_valid  = 1'b0;
    br_target = '0;
    halt_pc   = 12'hFFF;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_slot_v", 32'(out_slot_v), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_instr1", out_instr1, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'd0);

    // sequential stream with decode always ready
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("seq_en0", 32'(fetch_en), 32'd1);
    chk("seq_pc0", 32'(fetch_pc), 32'd0);
    cyc();
    chk("seq_pc1", 32'(fetch_pc), 32'd8);
    chk("seq_valid1", 32'(out_valid), 32'd1);
    chk("seq_opc1", 32'(out_pc), 32'd0);
    chk("seq_slot1", 32'(out_slot_v), 32'd3);
    chk("seq_i1", out_instr1, 32'hA000_0000);
    chk("seq_i2", out_instr2, 32'hB000_0004);
    cyc();
    chk("seq_pc2", 32'(fetch_pc), 32'd16);
    chk("seq_opc2", 32'(out_pc), 32'd8);
    cyc();
    chk("seq_pc3", 32'(fetch_pc), 32'd24);
    chk("seq_opc3", 32'(out_pc), 32'd16);

    // backpressure from reset: fill, hold, stable head
    reset     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk("bp_pc1", 32'(fetch_pc), 32'd8);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_pc_hold", 32'(fetch_pc), 32'd16);
      chk("bp_en", 32'(fetch_en), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_head_pc", 32'(out_pc), 32'd0);
      chk("bp_head_i1", out_instr1, 32'hA000_0000);
    end

    // misaligned redirect over a full FIFO
    br_valid  = 1'b1;
    br_target = 12'h124;
    out_ready = 1'b1;
    #1;
    chk("br_en_low", 32'(fetch_en), 32'd0);
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    chk("br_flush", 32'(out_valid), 32'd0);
    chk("br_pc", 32'(fetch_pc), 32'h120);
    chk("br_en", 32'(fetch_en), 32'd1);
    cyc();
    chk("br_opc1", 32'(out_pc), 32'h120);
    chk("br_slot1", 32'(out_slot_v), 32'd2);
    chk("br_pc2", 32'(fetch_pc), 32'h128);
    cyc();
    chk("br_opc2", 32'(out_pc), 32'h128);
    chk("br_slot2", 32'(out_slot_v), 32'd3);

    // wrap at the end of instruction memory
    br_valid  = 1'b1;
    br_target = 12'h7C0;
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    chk("wr_pc0", 32'(fetch_pc), 32'h7C0);
    cyc();
    chk("wr_pc1", 32'(fetch_pc), 32'h7C8);
    chk("wr_opc1", 32'(out_pc), 32'h7C0);
    cyc();
    chk("wr_pc2", 32'(fetch_pc), 32'h0);
    chk("wr_opc2", 32'(out_pc), 32'h7C8);
    cyc();
    chk("wr_pc3", 32'(fetch_pc), 32'h8);
    chk("wr_opc3", 32'(out_pc), 32'h0);

    // stop word in slot 0 at 0x40, then resume by redirect
    halt_pc   = 12'h040;
    br_valid  = 1'b1;
    br_target = 12'h030;
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    chk("h_pc0", 32'(fetch_pc), 32'h30);
    cyc();
    chk("h_pc1", 32'(fetch_pc), 32'h38);
    cyc();
    chk("h_pc2", 32'(fetch_pc), 32'h40);
    chk("h_not_yet", 32'(halted), 32'd0);
    chk("h_en_pre", 32'(fetch_en), 32'd1);
    cyc();
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_en", 32'(fetch_en), 32'd0);
    chk("h_opc", 32'(out_pc), 32'h40);
    chk("h_slot", 32'(out_slot_v), 32'd1);
    chk("h_i1", out_instr1, 32'h0000_0123);
    chk("h_pc_frz", 32'(fetch_pc), 32'h48);
    cyc();
    chk("h_drained", 32'(out_valid), 32'd0);
    chk("h_en2", 32'(fetch_en), 32'd0);
    cyc();
    chk("h_pc_frz2", 32'(fetch_pc), 32'h48);
    chk("h_still", 32'(halted), 32'd1);
    br_valid  = 1'b1;
    br_target = 12'h080;
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    chk("h_resume", 32'(halted), 32'd0);
    chk("h_res_pc", 32'(fetch_pc), 32'h80);
    chk("h_res_en", 32'(fetch_en), 32'd1);
    cyc();
    chk("h_res_opc", 32'(out_pc), 32'h80);
    chk("h_res_slot", 32'(out_slot_v), 32'd3);

    // asynchronous reset with a full FIFO
    out_ready = 1'b0;
    br_valid  = 1'b1;
    br_target = 12'h200;
    @(negedge clk);
    br_valid = 1'b0;
    cyc();
    cyc();
    chk("ar_full_valid", 32'(out_valid), 32'd1);
    chk("ar_full_en", 32'(fetch_en), 32'd0);
    chk("ar_full_pc", 32'(fetch_pc), 32'h210);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_pc", 32'(fetch_pc), 32'd0);
    chk("ar_en", 32'(fetch_en), 32'd0);
    chk("ar_opc", 32'(out_pc), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
